// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration sequencer.
//   - cfg_state_e : sequencer state encoding
//   - LUT word field positions ({dev_addr, reg_addr, data})
//   - LUT_INVALID : LUT word marking an entry that must not be written
//   - VOL_0DB     : headphone volume code for 0 dB
package wm8731_pkg;

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_FETCH = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_IDLE  = 3'd5
  } cfg_state_e;

  localparam int LUT_DEV_MSB = 31;
  localparam int LUT_DEV_LSB = 24;
  localparam int LUT_REG_MSB = 23;
  localparam int LUT_REG_LSB = 8;
  localparam int LUT_DAT_MSB = 7;
  localparam int LUT_DAT_LSB = 0;

  localparam logic [31:0] LUT_INVALID = 32'hFFFF_FFFF;
  localparam logic [6:0]  VOL_0DB     = 7'h79;

endpackage

// File: rtl/wm8731_cfg_ctrl_timer.sv
// cfg_powerup_timer: power-up delay down-counter.
// Loaded with CYCLES-1 on reset, decrements while en_i is high and
// reports done_o on the enabled cycle where it has reached zero, so the
// caller sees done_o on its CYCLES-th enabled cycle.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (reloads the count)
//   en_i   : count enable
//   done_o : delay elapsed (qualified by en_i)
module cfg_powerup_timer #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic done_o
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '0)) cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= LOAD;
    else       cnt_q <= cnt_d;
  end

  assign done_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/wm8731_cfg_ctrl.sv
// wm8731_cfg_ctrl: walks the WM8731 configuration LUT and issues one I2C
// register write per entry, then stays resident and rewrites only the two
// headphone-volume entries whenever volume_in differs from the latched
// volume.
//   clk, rst            : clock, synchronous active-high reset
//   volume_in           : live requested headphone volume
//   lut_index/lut_volume: address and volume driven to the LUT ROM
//   lut_data            : {dev_addr, reg_addr, data} from the LUT
//   i2c_*               : request/ack handshake to the I2C master
//   cfg_done, cfg_error : configuration complete / sticky retry exhaustion
// Handshake: i2c_write_req is raised with stable address/data and held
// until the one-cycle i2c_write_req_ack pulse; i2c_error is only meaningful
// on that ack cycle. Acks seen while not waiting are ignored.
module wm8731_cfg_ctrl
  import wm8731_pkg::*;
#(
  parameter int POWERUP_CYCLES = 1_000_000,
  parameter int LUT_SIZE       = 10,
  parameter int VOL_IDX_L      = 8,
  parameter int VOL_IDX_R      = 9,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  volume_in,
  output logic [9:0]  lut_index,
  output logic [6:0]  lut_volume,
  input  logic [31:0] lut_data,
  output logic        i2c_write_req,
  input  logic        i2c_write_req_ack,
  input  logic        i2c_error,
  output logic [7:0]  i2c_slave_dev_addr,
  output logic [15:0] i2c_slave_reg_addr,
  output logic [7:0]  i2c_write_data,
  output logic        cfg_done,
  output logic        cfg_error
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [9:0]    IDX_LAST = 10'(LUT_SIZE - 1);
  localparam logic [9:0]    IDX_L    = 10'(VOL_IDX_L);
  localparam logic [9:0]    IDX_R    = 10'(VOL_IDX_R);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  cfg_state_e    state_q, state_d;
  logic [9:0]    idx_q, idx_d;
  logic [6:0]    vol_q, vol_d;
  logic          req_q, req_d;
  logic [7:0]    dev_q, dev_d;
  logic [15:0]   reg_q, reg_d;
  logic [7:0]    dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          upd_q, upd_d;   // 1 while running a volume-only update pass
  logic [RW-1:0] retry_q, retry_d;
  logic          pwr_done;
  logic          lut_valid;
  logic          vol_changed;

  cfg_powerup_timer #(
    .CYCLES (POWERUP_CYCLES)
  ) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (state_q == S_PWRUP),
    .done_o (pwr_done)
  );

  assign lut_valid   = (lut_data != LUT_INVALID);
  assign vol_changed = (volume_in != vol_q);

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PWRUP;
      idx_q   <= '0;
      vol_q   <= VOL_0DB;
      req_q   <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vol_q   <= vol_d;
      req_q   <= req_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PWRUP: if (pwr_done) state_d = S_FETCH;
      S_FETCH: state_d = lut_valid ? S_REQ : S_NEXT;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (i2c_write_req_ack) begin
          if (i2c_error && (retry_q < RETRY_MAX)) state_d = S_REQ;
          else                                    state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (upd_q) state_d = (idx_q == IDX_L) ? S_FETCH : S_IDLE;
        else       state_d = (idx_q == IDX_LAST) ? S_IDLE : S_FETCH;
      end
      S_IDLE:  if (vol_changed) state_d = S_FETCH;
      default: state_d = S_PWRUP;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    idx_d   = idx_q;
    vol_d   = vol_q;
    req_d   = 1'b0;
    dev_d   = dev_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    err_d   = err_q;
    upd_d   = upd_q;
    retry_d = retry_q;
    case (state_q)
      S_PWRUP: begin
        if (pwr_done) begin
          vol_d = volume_in;
          idx_d = '0;
          upd_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (lut_valid) begin
          dev_d = lut_data[LUT_DEV_MSB:LUT_DEV_LSB];
          reg_d = lut_data[LUT_REG_MSB:LUT_REG_LSB];
          dat_d = lut_data[LUT_DAT_MSB:LUT_DAT_LSB];
        end
      end
      S_REQ:  req_d = 1'b1;
      S_WAIT: begin
        // Request drops on the edge that samples the ack.
        req_d = ~i2c_write_req_ack;
        if (i2c_write_req_ack) begin
          if (!i2c_error) begin
            retry_d = '0;
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
          end else begin
            // Out of retries: flag it and move on to the next entry.
            err_d   = 1'b1;
            retry_d = '0;
          end
        end
      end
      S_NEXT: begin
        if (upd_q) begin
          if (idx_q == IDX_L) idx_d = IDX_R;
        end else if (idx_q != IDX_LAST) begin
          idx_d = idx_q + 10'd1;
        end
      end
      S_IDLE: begin
        // volume_in is only sampled here, so the latest value wins.
        if (vol_changed) begin
          vol_d = volume_in;
          idx_d = IDX_L;
          upd_d = 1'b1;
        end
      end
      default: ;
    endcase
    done_d = (state_d == S_IDLE);
  end

  assign lut_index          = idx_q;
  assign lut_volume         = vol_q;
  assign i2c_write_req      = req_q;
  assign i2c_slave_dev_addr = dev_q;
  assign i2c_slave_reg_addr = reg_q;
  assign i2c_write_data     = dat_q;
  assign cfg_done           = done_q;
  assign cfg_error          = err_q;

endmodule

// File: tb/tb_wm8731_cfg_ctrl.sv
module tb_wm8731_cfg_ctrl;

  localparam int PWR  = 16;
  localparam int MAXR = 3;
  localparam int K_INIT = 0;
  localparam int K_UPD  = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]  volume_in = 7'h79;
  logic [9:0]  lut_index;
  logic [6:0]  lut_volume;
  logic [31:0] lut_data;
  logic        i2c_write_req;
  logic        i2c_write_req_ack = 1'b0;
  logic        i2c_error = 1'b0;
  logic [7:0]  i2c_slave_dev_addr;
  logic [15:0] i2c_slave_reg_addr;
  logic [7:0]  i2c_write_data;
  logic        cfg_done;
  logic        cfg_error;

  wm8731_cfg_ctrl #(
    .POWERUP_CYCLES (PWR),
    .LUT_SIZE       (10),
    .VOL_IDX_L      (8),
    .VOL_IDX_R      (9),
    .MAX_RETRY      (MAXR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .volume_in          (volume_in),
    .lut_index          (lut_index),
    .lut_volume         (lut_volume),
    .lut_data           (lut_data),
    .i2c_write_req      (i2c_write_req),
    .i2c_write_req_ack  (i2c_write_req_ack),
    .i2c_error          (i2c_error),
    .i2c_slave_dev_addr (i2c_slave_dev_addr),
    .i2c_slave_reg_addr (i2c_slave_reg_addr),
    .i2c_write_data     (i2c_write_data),
    .cfg_done           (cfg_done),
    .cfg_error          (cfg_error)
  );

  // ---------------- LUT ROM model ----------------
  int inv_idx = -1;

  function automatic logic [31:0] lut_word(int idx, logic [6:0] vol, int inv);
    if (idx == inv) return 32'hFFFF_FFFF;
    case (idx)
      0: return 32'h34_0000_97;
      1: return 32'h34_0002_97;
      2: return 32'h34_0008_12;
      3: return 32'h34_000A_00;
      4: return 32'h34_000C_00;
      5: return 32'h34_000E_42;
      6: return 32'h34_0010_00;
      7: return 32'h34_0012_01;
      8: return {8'h34, 16'h0004, 1'b0, vol};
      9: return {8'h34, 16'h0006, 1'b0, vol};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  assign lut_data = lut_word(int'(lut_index), lut_volume, inv_idx);

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int wr_cnt = 0;
  int nack_left[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_entry(int idx, logic [6:0] vol, int nacks);
    logic [31:0] w;
    int reps;
    w = lut_word(idx, vol, inv_idx);
    if (w == 32'hFFFF_FFFF) return;
    reps = 1 + ((nacks > MAXR) ? MAXR : nacks);
    repeat (reps) exp_q.push_back(w);
  endtask

  // ---------------- I2C master model (5-cycle ack latency) ----------------
  initial begin
    int lat;
    bit busy;
    busy = 0;
    lat  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 0;
        i2c_write_req_ack = 1'b0;
        i2c_error = 1'b0;
      end else if (i2c_write_req_ack) begin
        i2c_write_req_ack = 1'b0;
        i2c_error = 1'b0;
      end else if (busy) begin
        if (lat == 1) begin
          busy = 0;
          i2c_write_req_ack = 1'b1;
          if (lut_index < 10 && nack_left[lut_index] > 0) begin
            nack_left[lut_index]--;
            i2c_error = 1'b1;
          end
        end else begin
          lat--;
        end
      end else if (i2c_write_req) begin
        busy = 1;
        lat  = 5;
      end
    end
  end

  // Every completed write attempt is checked against the expected queue.
  always @(negedge clk) begin
    if (!rst && i2c_write_req && i2c_write_req_ack) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data}, 32'h0);
      end else begin
        chk("write_word", {i2c_slave_dev_addr, i2c_slave_reg_addr, i2c_write_data},
            exp_q.pop_front());
      end
      chk("done_low_in_pass", {31'b0, cfg_done}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_nacks();
    for (int i = 0; i < 10; i++) nack_left[i] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_lut_index", {22'b0, lut_index}, 32'd0);
    chk("rst_lut_volume", {25'b0, lut_volume}, 32'h79);
    chk("rst_req", {31'b0, i2c_write_req}, 32'd0);
    chk("rst_dev", {24'b0, i2c_slave_dev_addr}, 32'd0);
    chk("rst_reg", {16'b0, i2c_slave_reg_addr}, 32'd0);
    chk("rst_data", {24'b0, i2c_write_data}, 32'd0);
    chk("rst_done", {31'b0, cfg_done}, 32'd0);
    chk("rst_error", {31'b0, cfg_error}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_idle(string name, int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cfg_done && exp_q.size() == 0) ok = 1;
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_done_low(string name, int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!cfg_done) ok = 1;
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    int         kind;
    logic [6:0] vol;
    int         nack_idx;
    int         nack_n;
    int         inv;
    logic       exp_err;
    int         exp_writes;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bit ok;
    clear_nacks();
    vecs[0] = '{K_INIT, 7'h79, -1, 0, -1, 1'b0, 10};
    vecs[1] = '{K_UPD,  7'h50, -1, 0, -1, 1'b0, 2};
    vecs[2] = '{K_INIT, 7'h79,  3, 2, -1, 1'b0, 12};
    vecs[3] = '{K_INIT, 7'h79,  5, 4, -1, 1'b1, 13};
    vecs[4] = '{K_UPD,  7'h22, -1, 0, -1, 1'b1, 2};
    vecs[5] = '{K_UPD,  7'h33,  8, 1, -1, 1'b1, 3};
    vecs[6] = '{K_INIT, 7'h0A, -1, 0,  7, 1'b0, 9};

    for (int v = 0; v < 7; v++) begin
      clear_nacks();
      inv_idx = vecs[v].inv;
      exp_q.delete();
      wr_cnt = 0;
      volume_in = vecs[v].vol;
      if (vecs[v].nack_idx >= 0) nack_left[vecs[v].nack_idx] = vecs[v].nack_n;
      if (vecs[v].kind == K_INIT) begin
        for (int i = 0; i < 10; i++)
          push_entry(i, vecs[v].vol, (i == vecs[v].nack_idx) ? vecs[v].nack_n : 0);
        do_reset();
        wait_idle($sformatf("init_done_v%0d", v), 3000);
      end else begin
        push_entry(8, vecs[v].vol, (vecs[v].nack_idx == 8) ? vecs[v].nack_n : 0);
        push_entry(9, vecs[v].vol, (vecs[v].nack_idx == 9) ? vecs[v].nack_n : 0);
        wait_done_low($sformatf("upd_start_v%0d", v), 5);
        wait_idle($sformatf("upd_done_v%0d", v), 1000);
      end
      repeat (20) @(negedge clk);
      chk($sformatf("still_done_v%0d", v), {31'b0, cfg_done}, 32'd1);
      chk($sformatf("writes_v%0d", v), wr_cnt, vecs[v].exp_writes);
      chk($sformatf("cfg_error_v%0d", v), {31'b0, cfg_error}, {31'b0, vecs[v].exp_err});
      chk($sformatf("lut_volume_v%0d", v), {25'b0, lut_volume}, {25'b0, vecs[v].vol});
    end

    // Volume changes during an update pass: only the last value gets a pass.
    clear_nacks();
    inv_idx = -1;
    exp_q.delete();
    wr_cnt = 0;
    push_entry(8, 7'h40, 0);
    push_entry(9, 7'h40, 0);
    push_entry(8, 7'h70, 0);
    push_entry(9, 7'h70, 0);
    volume_in = 7'h40;
    wait_done_low("mid_pass_start", 5);
    repeat (3) @(negedge clk);
    volume_in = 7'h60;
    repeat (3) @(negedge clk);
    volume_in = 7'h70;
    wait_idle("mid_pass_done", 1000);
    repeat (20) @(negedge clk);
    chk("mid_pass_writes", wr_cnt, 4);
    chk("mid_pass_volume", {25'b0, lut_volume}, 32'h70);

    // Reset while waiting for the ack of entry 4.
    exp_q.delete();
    volume_in = 7'h79;
    for (int i = 0; i < 10; i++) push_entry(i, 7'h79, 0);
    do_reset();
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (lut_index == 10'd4 && i2c_write_req) ok = 1;
    end
    chk("reach_wait_4", {31'b0, ok}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'b0, i2c_write_req}, 32'd0);
    chk("midrst_index", {22'b0, lut_index}, 32'd0);
    chk("midrst_done", {31'b0, cfg_done}, 32'd0);
    exp_q.delete();
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) push_entry(i, 7'h79, 0);
    rst = 1'b0;
    ok = 1;
    for (int i = 0; i < PWR - 1; i++) begin
      @(negedge clk);
      if (i2c_write_req) ok = 0;
    end
    chk("powerup_quiet", {31'b0, ok}, 32'd1);
    wait_idle("restart_done", 3000);
    chk("restart_writes", wr_cnt, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
